// File: rtl/memory_wait_if.sv
// picorv32 native memory bus: the master drives the request, the slave returns rdata/ready.
interface memory_wait_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/memory_wait.sv
// Self-decoding on-chip RAM slave; mem_ready pulses 2+WAIT_STATES cycles after a request is sampled.
// No backpressure: outputs stay zero unless responding, so they can be wire-OR'ed with other slaves.
module memory_wait #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         reset,
    memory_wait_if.slave bus
);
    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] WIN_BYTES = 33'd1 << (ADDR_WIDTH + 2);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ram_we;
    logic [31:0]             ram [DEPTH];

    logic [31:0] offset;
    logic        sel;
    logic        unused_instr;

    // Unsigned subtract makes addresses below the base wrap high and miss.
    assign offset       = bus.mem_addr - BASE_ADDR;
    assign sel          = bus.mem_valid && ({1'b0, offset} < WIN_BYTES);
    assign unused_instr = bus.mem_instr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    idx_d   = offset[ADDR_WIDTH+1:2];
                    wstrb_d = bus.mem_wstrb;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = WS;
                    state_d = (WS != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!bus.mem_valid) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Old word is captured on the same edge that commits the write.
                rdata_d = ram[idx_q];
                ram_we  = |wstrb_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = (state_q == S_RESP);
    assign bus.mem_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
endmodule

// File: tb/tb_memory_wait.sv
// Two instances (base 0x1000 no wait states, base 0x2000 three wait states) share one wire-OR'ed bus.
module tb_memory_wait;
    localparam int AW = 6;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] rdata;
    logic        ready;

    always #5 clk = ~clk;

    memory_wait_if bus0 ();
    memory_wait_if bus3 ();

    assign bus0.mem_valid = valid;
    assign bus0.mem_instr = instr;
    assign bus0.mem_wstrb = wstrb;
    assign bus0.mem_wdata = wdata;
    assign bus0.mem_addr  = addr;
    assign bus3.mem_valid = valid;
    assign bus3.mem_instr = instr;
    assign bus3.mem_wstrb = wstrb;
    assign bus3.mem_wdata = wdata;
    assign bus3.mem_addr  = addr;
    assign rdata = bus0.mem_rdata | bus3.mem_rdata;
    assign ready = bus0.mem_ready | bus3.mem_ready;

    memory_wait #(.BASE_ADDR(32'h1000), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    memory_wait #(.BASE_ADDR(32'h2000), .ADDR_WIDTH(AW), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          known;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mem_m [bit [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    endtask

    function automatic int ws_of(input logic [31:0] a);
        return (a >= 32'h2000) ? 3 : 0;
    endfunction

    // One complete request; expected response is queued before driving and popped at mem_ready.
    task automatic xact(input string tag, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int unsigned t_rdy);
        exp_t        e;
        bit [31:0]   w;
        logic [31:0] nv;
        int          n;
        bit          seen;
        bit          noisy;
        w = a & ~32'h3;
        nv = mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
        e.known = mem_m.exists(w) && !$isunknown(mem_m[w]);
        e.val = nv;
        sb_q.push_back(e);
        if (s != 4'd0) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) nv[8*i +: 8] = d[8*i +: 8];
            mem_m[w] = nv;
        end
        addr = a; wstrb = s; wdata = d; valid = 1'b1;
        n = 0; seen = 1'b0; noisy = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = ready;
            if (!seen && rdata != 32'd0) noisy = 1'b1;
        end
        chk({tag, ".latency"}, n, ws_of(a) + 2);
        chk({tag, ".quiet"}, {31'd0, noisy}, 32'd0);
        rd = rdata;
        t_rdy = cyc;
        e = sb_q.pop_front();
        if (e.known) chk({tag, ".data"}, rdata, e.val);
        valid = 1'b0; wstrb = 4'd0;
        @(posedge clk); #1;
        chk({tag, ".ready_low"}, {31'd0, ready}, 32'd0);
    endtask

    // Holds a request that must not be answered for 10 cycles.
    task automatic no_resp(input string tag, input logic [31:0] a, input logic v,
                           input logic [3:0] s, input logic [31:0] d);
        bit bad;
        bad = 1'b0;
        addr = a; valid = v; wstrb = s; wdata = d;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready || rdata != 32'd0) bad = 1'b1;
        end
        chk(tag, {31'd0, bad}, 32'd0);
        valid = 1'b0; wstrb = 4'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned t;
        int unsigned tt [8];
        int          n;

        #12;
        chk("reset.ready", {31'd0, ready}, 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        xact("wr_1004", 32'h1004, 4'hF, 32'hDEAD_BEEF, rd, t);
        xact("rd_1004", 32'h1004, 4'h0, 32'h0, rd, t);
        chk("basic.value", rd, 32'hDEAD_BEEF);

        xact("lane0", 32'h1004, 4'b0001, 32'h0000_0055, rd, t);
        xact("lane2", 32'h1004, 4'b0100, 32'h00AA_0000, rd, t);
        xact("rd_lanes", 32'h1004, 4'h0, 32'h0, rd, t);
        chk("lanes.value", rd, 32'hDEAA_BE55);

        xact("wr_2000", 32'h2000, 4'hF, 32'hCAFE_F00D, rd, t);
        xact("rd_2000", 32'h2000, 4'h0, 32'h0, rd, t);
        xact("wr_1000", 32'h1000, 4'hF, 32'h1111_1111, rd, t);

        no_resp("miss.below", 32'h0000_0FFC, 1'b1, 4'hF, 32'hBAD0_0001);
        no_resp("miss.above", 32'h1000 + (32'd4 << AW), 1'b1, 4'hF, 32'hBAD0_0002);
        no_resp("miss.novalid", 32'h1000, 1'b0, 4'hF, 32'hBAD0_0003);
        xact("rd_1000_after_miss", 32'h1000, 4'h0, 32'h0, rd, t);
        xact("rd_1004_after_miss", 32'h1004, 4'h0, 32'h0, rd, t);

        xact("wr_2004", 32'h2004, 4'hF, 32'hAAAA_5555, rd, t);
        addr = 32'h2004; wstrb = 4'hF; wdata = 32'h1234_5678; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 4'd0;
        no_resp("abort.no_ready", 32'h2004, 1'b0, 4'h0, 32'h0);
        xact("rd_2004_after_abort", 32'h2004, 4'h0, 32'h0, rd, t);

        addr = 32'h2000; wstrb = 4'h0; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; valid = 1'b0;
        #1;
        chk("rst_wait.ready", {31'd0, ready}, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        xact("rd_2000_after_rst", 32'h2000, 4'h0, 32'h0, rd, t);

        addr = 32'h1004; wstrb = 4'h0; valid = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_resp.seen", {31'd0, ready}, 32'd1);
        reset = 1'b1; valid = 1'b0;
        #1;
        chk("rst_resp.ready", {31'd0, ready}, 32'd0);
        chk("rst_resp.rdata", rdata, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        xact("rd_1004_after_rst", 32'h1004, 4'h0, 32'h0, rd, t);

        for (int i = 0; i < 8; i++)
            xact("tp_wr", 32'h1010 + 32'(4 * i), 4'hF, (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000, rd, t);
        for (int i = 0; i < 8; i++)
            xact("tp_rd", 32'h1010 + 32'(4 * i), 4'h0, 32'h0, rd, tt[i]);
        for (int i = 1; i < 8; i++)
            chk("tp.spacing", tt[i] - tt[i-1], 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
